// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU interface definitions: ALUOp codes and MIPS opcode/funct constants.
// Used by the issue stage, its decoder and the ALU that consumes out_alu_op.
package alu_issue_stage_pkg;

  typedef enum logic [4:0] {
    ALU_NOP  = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_ADDU = 5'd2,
    ALU_SUB  = 5'd3,
    ALU_SUBU = 5'd4,
    ALU_AND  = 5'd5,
    ALU_OR   = 5'd6,
    ALU_XOR  = 5'd7,
    ALU_NOR  = 5'd8,
    ALU_SLT  = 5'd9,
    ALU_SLTU = 5'd10,
    ALU_SLL  = 5'd11,
    ALU_SRL  = 5'd12,
    ALU_SRA  = 5'd13,
    ALU_LUI  = 5'd14,
    ALU_EQL  = 5'd15,
    ALU_BNE  = 5'd16,
    ALU_LE0  = 5'd17,
    ALU_GT0  = 5'd18,
    ALU_LT0  = 5'd19,
    ALU_GE0  = 5'd20
  } alu_op_e;

  localparam logic [5:0] OPC_RTYPE  = 6'h00;
  localparam logic [5:0] OPC_REGIMM = 6'h01;
  localparam logic [5:0] OPC_BEQ    = 6'h04;
  localparam logic [5:0] OPC_BNE    = 6'h05;
  localparam logic [5:0] OPC_BLEZ   = 6'h06;
  localparam logic [5:0] OPC_BGTZ   = 6'h07;
  localparam logic [5:0] OPC_ADDI   = 6'h08;
  localparam logic [5:0] OPC_ADDIU  = 6'h09;
  localparam logic [5:0] OPC_SLTI   = 6'h0A;
  localparam logic [5:0] OPC_SLTIU  = 6'h0B;
  localparam logic [5:0] OPC_ANDI   = 6'h0C;
  localparam logic [5:0] OPC_ORI    = 6'h0D;
  localparam logic [5:0] OPC_XORI   = 6'h0E;
  localparam logic [5:0] OPC_LUI    = 6'h0F;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  // Unknown funct codes map to NOP; the caller flags them illegal.
  function automatic logic [4:0] rtype_alu_op(input logic [5:0] funct);
    case (funct)
      FUNCT_SLL:  return ALU_SLL;
      FUNCT_SRL:  return ALU_SRL;
      FUNCT_SRA:  return ALU_SRA;
      FUNCT_ADD:  return ALU_ADD;
      FUNCT_ADDU: return ALU_ADDU;
      FUNCT_SUB:  return ALU_SUB;
      FUNCT_SUBU: return ALU_SUBU;
      FUNCT_AND:  return ALU_AND;
      FUNCT_OR:   return ALU_OR;
      FUNCT_XOR:  return ALU_XOR;
      FUNCT_NOR:  return ALU_NOR;
      FUNCT_SLT:  return ALU_SLT;
      FUNCT_SLTU: return ALU_SLTU;
      default:    return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational decode of one MIPS instruction plus register read data
// into the ALU bundle {alu_op, in_a, in_b, dst, wr_en, illegal}.
module alu_op_decode
  import alu_issue_stage_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic [31:0]           instr,
  input  logic [WORD_WIDTH-1:0] rs_data,
  input  logic [WORD_WIDTH-1:0] rt_data,
  output logic [4:0]            alu_op,
  output logic [WORD_WIDTH-1:0] in_a,
  output logic [WORD_WIDTH-1:0] in_b,
  output logic [4:0]            dst,
  output logic                  wr_en,
  output logic                  illegal
);

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [4:0]            rt_idx;
  logic [4:0]            rd_idx;
  logic [WORD_WIDTH-1:0] imm_sext;
  logic [WORD_WIDTH-1:0] imm_zext;
  logic [WORD_WIDTH-1:0] shamt_zext;
  logic                  writes;
  logic                  unused_rs_field;

  assign opcode     = instr[31:26];
  assign funct      = instr[5:0];
  assign rt_idx     = instr[20:16];
  assign rd_idx     = instr[15:11];
  assign imm_sext   = {{(WORD_WIDTH-16){instr[15]}}, instr[15:0]};
  assign imm_zext   = {{(WORD_WIDTH-16){1'b0}}, instr[15:0]};
  assign shamt_zext = {{(WORD_WIDTH-5){1'b0}}, instr[10:6]};
  // The rs index is resolved by the register file; only its data arrives here.
  assign unused_rs_field = ^instr[25:21];

  always_comb begin
    alu_op  = ALU_NOP;
    in_a    = '0;
    in_b    = '0;
    dst     = '0;
    writes  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FUNCT_SLL, FUNCT_SRL, FUNCT_SRA: begin
            alu_op = rtype_alu_op(funct);
            in_a   = rt_data;
            in_b   = shamt_zext;
            dst    = rd_idx;
            writes = 1'b1;
          end
          FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU, FUNCT_AND, FUNCT_OR,
          FUNCT_XOR, FUNCT_NOR, FUNCT_SLT, FUNCT_SLTU: begin
            alu_op = rtype_alu_op(funct);
            in_a   = rs_data;
            in_b   = rt_data;
            dst    = rd_idx;
            writes = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_ADDI:  begin alu_op = ALU_ADD;  in_a = rs_data; in_b = imm_sext; dst = rt_idx; writes = 1'b1; end
      OPC_ADDIU: begin alu_op = ALU_ADDU; in_a = rs_data; in_b = imm_sext; dst = rt_idx; writes = 1'b1; end
      OPC_SLTI:  begin alu_op = ALU_SLT;  in_a = rs_data; in_b = imm_sext; dst = rt_idx; writes = 1'b1; end
      OPC_SLTIU: begin alu_op = ALU_SLTU; in_a = rs_data; in_b = imm_sext; dst = rt_idx; writes = 1'b1; end
      OPC_ANDI:  begin alu_op = ALU_AND;  in_a = rs_data; in_b = imm_zext; dst = rt_idx; writes = 1'b1; end
      OPC_ORI:   begin alu_op = ALU_OR;   in_a = rs_data; in_b = imm_zext; dst = rt_idx; writes = 1'b1; end
      OPC_XORI:  begin alu_op = ALU_XOR;  in_a = rs_data; in_b = imm_zext; dst = rt_idx; writes = 1'b1; end
      // LUI: the ALU performs the shift by 16.
      OPC_LUI:   begin alu_op = ALU_LUI;                  in_b = imm_zext; dst = rt_idx; writes = 1'b1; end
      OPC_BEQ:   begin alu_op = ALU_EQL;  in_a = rs_data; in_b = rt_data; end
      OPC_BNE:   begin alu_op = ALU_BNE;  in_a = rs_data; in_b = rt_data; end
      OPC_BLEZ:  begin alu_op = ALU_LE0;  in_a = rs_data; end
      OPC_BGTZ:  begin alu_op = ALU_GT0;  in_a = rs_data; end
      OPC_REGIMM: begin
        case (rt_idx)
          5'd0:    begin alu_op = ALU_LT0; in_a = rs_data; end
          5'd1:    begin alu_op = ALU_GE0; in_a = rs_data; end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign wr_en = writes & (dst != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register holding the decoded ALU bundle behind a valid/ready handshake.
// Define ALU_ISSUE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [WORD_WIDTH-1:0] in_rs_data,
  input  logic [WORD_WIDTH-1:0] in_rt_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            out_alu_op,
  output logic [WORD_WIDTH-1:0] out_in_a,
  output logic [WORD_WIDTH-1:0] out_in_b,
  output logic [4:0]            out_dst,
  output logic                  out_wr_en,
  output logic                  out_illegal
);

  localparam int BW = 2*WORD_WIDTH + 12;

  // Handshake: a beat moves on a port when valid and ready are both high at
  // the rising edge; valid is never withdrawn and data stays stable until then.
  logic [4:0]            dec_op;
  logic [WORD_WIDTH-1:0] dec_a;
  logic [WORD_WIDTH-1:0] dec_b;
  logic [4:0]            dec_dst;
  logic                  dec_wr_en;
  logic                  dec_illegal;
  logic [BW-1:0]         dec_bundle;
  logic [BW-1:0]         head;
  logic                  push;
  logic                  pop;

  alu_op_decode #(.WORD_WIDTH(WORD_WIDTH)) u_decode (
    .instr   (in_instr),
    .rs_data (in_rs_data),
    .rt_data (in_rt_data),
    .alu_op  (dec_op),
    .in_a    (dec_a),
    .in_b    (dec_b),
    .dst     (dec_dst),
    .wr_en   (dec_wr_en),
    .illegal (dec_illegal)
  );

  assign dec_bundle = {dec_op, dec_a, dec_b, dec_dst, dec_wr_en, dec_illegal};
  assign {out_alu_op, out_in_a, out_in_b, out_dst, out_wr_en, out_illegal} = head;
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

`ifdef ALU_ISSUE_SKID_EN
  logic [BW-1:0] slot1;
  logic [1:0]    count;
  logic [1:0]    count_next;
  logic          ready_q;

  always_comb begin
    count_next = count;
    if (flush)
      count_next = 2'd0;
    else if (push && !pop)
      count_next = count + 2'd1;
    else if (pop && !push)
      count_next = count - 2'd1;
  end

  assign out_valid = (count != 2'd0);
  assign in_ready  = ready_q;

  // head is the oldest entry; slot1 only ever holds the entry behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      slot1   <= '0;
      count   <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      count   <= count_next;
      ready_q <= (count_next != 2'd2);
      if (!flush) begin
        if (pop) begin
          if (count == 2'd2) head <= slot1;
          if (push) begin
            if (count == 2'd2) slot1 <= dec_bundle;
            else               head  <= dec_bundle;
          end
        end else if (push) begin
          if (count == 2'd0) head  <= dec_bundle;
          else               slot1 <= dec_bundle;
        end
      end
    end
  end
`else
  logic valid_q;

  assign out_valid = valid_q;
  assign in_ready  = !valid_q | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) head <= dec_bundle;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: queue-based reference model checked
// every cycle, plus directed literal cases for decode, stalls, flush and reset.
module tb_alu_issue_stage;

  localparam int W  = 32;
  localparam int BW = 2*W + 12;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_ADDU = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd13;
  localparam logic [4:0] OP_LT0  = 5'd19;
  localparam logic [4:0] OP_GE0  = 5'd20;

  // ALU op for I-type opcodes 0x08..0x0F
  localparam int ITYPE_OP [8] = '{1, 2, 9, 10, 5, 6, 7, 14};
  localparam logic [5:0] LEGAL_FN [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                           6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic [W-1:0]  in_rs_data;
  logic [W-1:0]  in_rt_data;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    out_alu_op;
  logic [W-1:0]  out_in_a;
  logic [W-1:0]  out_in_b;
  logic [4:0]    out_dst;
  logic          out_wr_en;
  logic          out_illegal;
  logic [BW-1:0] dut_bundle;

  alu_issue_stage #(.WORD_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs_data  (in_rs_data),
    .in_rt_data  (in_rt_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_alu_op  (out_alu_op),
    .out_in_a    (out_in_a),
    .out_in_b    (out_in_b),
    .out_dst     (out_dst),
    .out_wr_en   (out_wr_en),
    .out_illegal (out_illegal)
  );

  assign dut_bundle = {out_alu_op, out_in_a, out_in_b, out_dst, out_wr_en, out_illegal};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [BW-1:0] exp_q[$];
  logic          cap_in    = 1'b0;
  logic          cap_out   = 1'b0;
  logic          cap_flush = 1'b0;
  logic [BW-1:0] cap_b     = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-set rules.
  function automatic logic [BW-1:0] model(input logic [31:0] ins, input logic [W-1:0] rs,
                                          input logic [W-1:0] rt);
    int opc;
    int fn;
    int rtf;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   d;
    logic         wr;
    logic         ill;
    logic [W-1:0] simm;
    logic [W-1:0] zimm;
    opc  = int'(ins[31:26]);
    fn   = int'(ins[5:0]);
    rtf  = int'(ins[20:16]);
    simm = {{(W-16){ins[15]}}, ins[15:0]};
    zimm = {{(W-16){1'b0}}, ins[15:0]};
    op = 5'd0; a = '0; b = '0; d = 5'd0; wr = 1'b0; ill = 1'b0;
    if (opc == 0 && fn >= 32 && fn <= 39) begin
      op = 5'(fn - 31); a = rs; b = rt; d = ins[15:11]; wr = 1'b1;
    end else if (opc == 0 && (fn == 42 || fn == 43)) begin
      op = 5'(fn - 33); a = rs; b = rt; d = ins[15:11]; wr = 1'b1;
    end else if (opc == 0 && (fn == 0 || fn == 2 || fn == 3)) begin
      op = (fn == 0) ? 5'd11 : 5'(fn + 10);
      a = rt; b = {{(W-5){1'b0}}, ins[10:6]}; d = ins[15:11]; wr = 1'b1;
    end else if (opc >= 8 && opc <= 15) begin
      op = 5'(ITYPE_OP[opc-8]);
      a  = (opc == 15) ? '0 : rs;
      b  = (opc < 12) ? simm : zimm;
      d  = ins[20:16]; wr = 1'b1;
    end else if (opc >= 4 && opc <= 7) begin
      op = 5'(opc + 11); a = rs; b = (opc < 6) ? rt : '0;
    end else if (opc == 1 && rtf < 2) begin
      op = 5'(19 + rtf); a = rs;
    end else begin
      ill = 1'b1;
    end
    wr = wr && (d != 5'd0);
    return {op, a, b, d, wr, ill};
  endfunction

  // compare process: checks every falling edge, then captures the handshakes
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_out_valid", 128'(out_valid), 128'(0));
      chk("reset_bundle", 128'(dut_bundle), 128'(0));
      cap_in = 1'b0; cap_out = 1'b0; cap_flush = 1'b0;
    end else begin
      chk("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("bundle", 128'(dut_bundle), 128'(exp_q[0]));
`ifdef ALU_ISSUE_SKID_EN
      chk("in_ready", 128'(in_ready), 128'(exp_q.size() < 2));
`else
      chk("in_ready", 128'(in_ready), 128'((exp_q.size() == 0) || out_ready));
`endif
      cap_in    = in_valid && in_ready;
      cap_out   = (exp_q.size() != 0) && out_ready;
      cap_flush = flush;
      cap_b     = model(in_instr, in_rs_data, in_rt_data);
    end
  end

  // scoreboard queue update
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (cap_flush) begin
      exp_q.delete();
    end else begin
      if (cap_out) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (cap_in) exp_q.push_back(cap_b);
    end
  end

  // driver tasks: called at posedge+1, return at the negedge showing the result
  task automatic send(input logic [31:0] ins, input logic [W-1:0] rs, input logic [W-1:0] rt);
    in_valid = 1'b1; in_instr = ins; in_rs_data = rs; in_rt_data = rt;
    out_ready = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int r;
    ins = $urandom;
    r = $urandom_range(0, 9);
    if (r <= 2)      ins[31:26] = 6'h00;
    else if (r == 3) ins[31:26] = 6'h01;
    else if (r == 4) ins[31:26] = 6'($urandom_range(4, 7));
    else if (r <= 7) ins[31:26] = 6'($urandom_range(8, 15));
    else             ins[31:26] = 6'($urandom_range(16, 63));
    if (ins[31:26] == 6'h00 && $urandom_range(0, 4) != 0)
      ins[5:0] = LEGAL_FN[$urandom_range(0, 12)];
    ins[20:16] = (ins[31:26] == 6'h01) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(0, 7));
    ins[15:11] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    int k;
    int p0;
    logic acc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    in_rs_data = '0; in_rt_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    realign();

    // ADDI $5,$1,-1
    send(32'h2025FFFF, 32'd7, 32'd0);
    chk("addi_op", 128'(out_alu_op), 128'(OP_ADD));
    chk("addi_a", 128'(out_in_a), 128'(32'd7));
    chk("addi_b", 128'(out_in_b), 128'(32'hFFFF_FFFF));
    chk("addi_dst", 128'(out_dst), 128'(5'd5));
    chk("addi_wr", 128'(out_wr_en), 128'(1'b1));
    realign();

    // ORI $2,$0,0x8000
    send(32'h34028000, 32'd0, 32'd0);
    chk("ori_op", 128'(out_alu_op), 128'(OP_OR));
    chk("ori_b", 128'(out_in_b), 128'(32'h0000_8000));
    realign();

    // SRA $3,$4,4
    send(32'h00041903, 32'd0, 32'h8000_0000);
    chk("sra_op", 128'(out_alu_op), 128'(OP_SRA));
    chk("sra_a", 128'(out_in_a), 128'(32'h8000_0000));
    chk("sra_b", 128'(out_in_b), 128'(32'd4));
    chk("sra_dst", 128'(out_dst), 128'(5'd3));
    realign();

    // opcode 0x3F is illegal
    send(32'hFC00_1234, 32'd9, 32'd9);
    chk("ill_flag", 128'(out_illegal), 128'(1'b1));
    chk("ill_op", 128'(out_alu_op), 128'(OP_NOP));
    chk("ill_ab", 128'({out_in_a, out_in_b}), 128'(0));
    chk("ill_wr", 128'(out_wr_en), 128'(1'b0));
    realign();

    // BLTZ $1 / BGEZ $1
    send(32'h0420_0010, 32'd5, 32'd0);
    chk("bltz_op", 128'(out_alu_op), 128'(OP_LT0));
    chk("bltz_wr", 128'(out_wr_en), 128'(1'b0));
    realign();
    send(32'h0421_0010, 32'd5, 32'd0);
    chk("bgez_op", 128'(out_alu_op), 128'(OP_GE0));
    chk("bgez_wr", 128'(out_wr_en), 128'(1'b0));
    realign();

    // ADDU $0,$1,$2: legal but never written back
    send(32'h0022_0021, 32'd1, 32'd2);
    chk("addu0_op", 128'(out_alu_op), 128'(OP_ADDU));
    chk("addu0_wr", 128'(out_wr_en), 128'(1'b0));
    chk("addu0_ill", 128'(out_illegal), 128'(1'b0));
    realign();

    // stream of 4 with out_ready low for the first 3 cycles
    p0 = pops;
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      in_valid = 1'b1; in_instr = 32'h2021_0000 | 32'(k);
      in_rs_data = 32'(100 + k); in_rt_data = '0;
      out_ready = (cyc >= 3);
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) k++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("stream_accepted", 128'(k), 128'(4));
    chk("stream_emitted", 128'(pops - p0), 128'(4));

    // flush coincident with an accept and a held entry
    in_valid = 1'b1; in_instr = 32'h2042_0005; in_rs_data = 32'd3; out_ready = 1'b0;
    realign();
    in_instr = 32'h2063_0006; flush = 1'b1;
`ifdef ALU_ISSUE_SKID_EN
    out_ready = 1'b0;
`else
    out_ready = 1'b1;
`endif
    @(negedge clk);
    chk("flush_in_ready", 128'(in_ready), 128'(1'b1));
    realign();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 128'(out_valid), 128'(1'b0));
    @(negedge clk);
    chk("flush_out_valid2", 128'(out_valid), 128'(1'b0));
    realign();

    // asynchronous reset with an entry held
    in_valid = 1'b1; in_instr = 32'h2025FFFF; in_rs_data = 32'd7; out_ready = 1'b0;
    realign();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", 128'(out_valid), 128'(1'b1));
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 128'(out_valid), 128'(1'b0));
    chk("async_reset_op", 128'(out_alu_op), 128'(OP_NOP));
    @(negedge clk); #2 rst_n = 1'b1;
    realign();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 31) == 0);
      in_instr   = rand_instr();
      in_rs_data = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
      in_rt_data = $urandom;
      realign();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("final_idle", 128'(out_valid), 128'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "time limit");
  end

endmodule
